// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO stream transmitter.
//   - FSM state encodings (plain localparams so older tools can consume them)
//   - TX_IDLE_LEVEL: level driven on the serial line whenever no frame is in flight
//   - cnt_width(): width of a counter that must hold the values 0..n-1
package fifo_stream_pkg;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRequest = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StStart   = 3'd3;
  localparam logic [2:0] StData    = 3'd4;
  localparam logic [2:0] StParity  = 3'd5;
  localparam logic [2:0] StStop    = 3'd6;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // A counter of n states needs $clog2(n) bits, but never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer for the serial transmitter.
// Counts clk cycles while enabled and pulses tick_o on the last cycle of every line bit, then
// reloads, so each bit lasts exactly CLKS_PER_BIT cycles with no accumulated drift.
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   en_i       in   count while high; counter held at zero while low
//   restart_i  in   force the counter back to zero (asserted on entry to the start bit)
//   tick_o     out  one-cycle pulse on the final cycle of a bit period
module baud_tick_gen
  import fifo_stream_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_stream_tx.sv
// FIFO-to-UART stream transmitter.
// Pulls one word at a time from a FIFO over a four-phase ready/valid handshake, then sends it
// on a UART-style line: start bit (0), WORD_LENGTH data bits LSB first, optional even parity
// bit, stop bit (1). The line idles high and is driven from a flop.
// Optional feature: define FIFO_STREAM_TX_PARITY_EN to insert an even-parity bit between the
// last data bit and the stop bit.
// Ports:
//   clk            in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   data_in        in   word from the FIFO
//   data_in_valid  in   FIFO word valid
//   ready_in       out  request to the FIFO (high in REQUEST and CAPTURE)
//   tx             out  serial line, idle high, registered
//   busy           out  high while a captured word is being sent
//   word_done      out  one-cycle pulse on the last cycle of the stop bit
module fifo_stream_tx
  import fifo_stream_pkg::*;
#(
  parameter int unsigned WORD_LENGTH  = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SAMPLE_DELAY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   data_in_valid,
  output logic                   ready_in,
  output logic                   tx,
  output logic                   busy,
  output logic                   word_done
);

  localparam int unsigned BitW = cnt_width(WORD_LENGTH);
  localparam logic [BitW-1:0] BitLast = BitW'(WORD_LENGTH - 1);
  localparam logic [1:0] SampleDelay = 2'(SAMPLE_DELAY);

  logic [2:0]             state_q, state_d;
  logic [1:0]             dly_q, dly_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
`ifdef FIFO_STREAM_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic baud_tick;
  logic baud_restart;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_i     (busy),
    .restart_i(baud_restart),
    .tick_o   (baud_tick)
  );

  // Handshake and status outputs decode straight from the state so that an asynchronous reset
  // clears them in the same cycle.
  assign ready_in  = (state_q == StRequest) || (state_q == StCapture);
  assign busy      = (state_q == StStart) || (state_q == StData) ||
                     (state_q == StParity) || (state_q == StStop);
  assign word_done = (state_q == StStop) && baud_tick;
  assign tx        = tx_q;

  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
`ifdef FIFO_STREAM_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    baud_restart = 1'b0;

    unique case (state_q)
      // Wait for the previous handshake to close before asking for another word.
      StIdle: begin
        if (!data_in_valid) begin
          state_d = StRequest;
        end
      end

      StRequest: begin
        if (data_in_valid) begin
          dly_d   = '0;
          state_d = StCapture;
        end
      end

      // Valid must stay high for SAMPLE_DELAY more cycles before the word is trusted.
      StCapture: begin
        if (!data_in_valid) begin
          state_d = StIdle;
        end else if (dly_q == SampleDelay) begin
          shift_d      = data_in;
`ifdef FIFO_STREAM_TX_PARITY_EN
          parity_d     = ^data_in;
`endif
          bit_cnt_d    = '0;
          baud_restart = 1'b1;
          state_d      = StStart;
        end else begin
          dly_d = dly_q + 2'd1;
        end
      end

      StStart: begin
        if (baud_tick) begin
          state_d = StData;
        end
      end

      StData: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
`ifdef FIFO_STREAM_TX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

`ifdef FIFO_STREAM_TX_PARITY_EN
      StParity: begin
        if (baud_tick) begin
          state_d = StStop;
        end
      end
`endif

      StStop: begin
        if (baud_tick) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The line level is computed from the next state so the registered tx lines up with state_q.
  always_comb begin
    tx_d = TX_IDLE_LEVEL;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef FIFO_STREAM_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      dly_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= TX_IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

`ifdef FIFO_STREAM_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_tx.sv
// Directed bench for fifo_stream_tx (CLKS_PER_BIT=4, SAMPLE_DELAY=2).
// A behavioural FIFO feeds the handshake; a line monitor rebuilds each frame bit by bit.
module tb_fifo_stream_tx;

  localparam int unsigned W  = 8;
  localparam int unsigned C  = 4;
  localparam int unsigned SD = 2;
`ifdef FIFO_STREAM_TX_PARITY_EN
  localparam int unsigned NBITS = W + 3;
  localparam logic [NBITS-1:0] A5_FRAME = 11'h54A;
`else
  localparam int unsigned NBITS = W + 2;
  localparam logic [NBITS-1:0] A5_FRAME = 10'h34A;
`endif
  localparam int unsigned FRAME = NBITS * C;
  localparam int unsigned IW = $clog2(NBITS);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_in_valid = 1'b0;
  logic         ready_in, tx, busy, word_done;

  fifo_stream_tx #(
    .WORD_LENGTH (W),
    .CLKS_PER_BIT(C),
    .SAMPLE_DELAY(SD)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .ready_in     (ready_in),
    .tx           (tx),
    .busy         (busy),
    .word_done    (word_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NBITS-1:0] exp_frame(input logic [W-1:0] d);
`ifdef FIFO_STREAM_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // ---------------- line monitor ----------------
  logic [NBITS-1:0] frames_q[$];
  bit               glitch_q[$];
  int               donepos_q[$];
  int               done_cnt = 0;
  logic [NBITS-1:0] mon_bits;
  bit               mon_on = 1'b0;
  bit               mon_glitch;
  int               mon_pos;
  int               mon_done_pos;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      mon_on = 1'b0;
    end else begin
      if (word_done) done_cnt++;
      if (!mon_on && tx == 1'b0) begin
        mon_on = 1'b1;
        mon_pos = 0;
        mon_glitch = 1'b0;
        mon_done_pos = -1;
        mon_bits = '0;
      end
      if (mon_on) begin
        if (mon_pos % C == 0) mon_bits[IW'(mon_pos / C)] = tx;
        else if (mon_bits[IW'(mon_pos / C)] !== tx) mon_glitch = 1'b1;
        if (word_done) mon_done_pos = mon_pos;
        mon_pos++;
        if (mon_pos == FRAME) begin
          frames_q.push_back(mon_bits);
          glitch_q.push_back(mon_glitch);
          donepos_q.push_back(mon_done_pos);
          mon_on = 1'b0;
        end
      end
    end
  end

  // ---------------- FIFO model and helpers ----------------
  logic [W-1:0] fifo_q[$];
  int           rd_idx = 0;

  // Four-phase producer: present a word on request, withdraw it once ready_in falls.
  task automatic fifo_step();
    if (data_in_valid && !ready_in) begin
      data_in_valid = 1'b0;
      void'(fifo_q.pop_front());
    end else if (!data_in_valid && ready_in && fifo_q.size() > 0) begin
      data_in       = fifo_q[0];
      data_in_valid = 1'b1;
    end
  endtask

  task automatic run_until(input int n_new, input int budget, input bit serve, input string tag);
    int i = 0;
    while ((frames_q.size() - rd_idx) < n_new && i < budget) begin
      @(negedge clk);
      if (serve) fifo_step();
      i++;
    end
    if ((frames_q.size() - rd_idx) < n_new)
      check({tag, " timeout"}, 32'(frames_q.size() - rd_idx), 32'(n_new));
  endtask

  task automatic check_frame(input string tag, input logic [NBITS-1:0] exp);
    if (frames_q.size() <= rd_idx) begin
      check({tag, " missing"}, 32'(frames_q.size() - rd_idx), 1);
    end else begin
      check({tag, " bits"}, 32'(frames_q[rd_idx]), 32'(exp));
      check({tag, " glitch"}, 32'(glitch_q[rd_idx]), 0);
      check({tag, " done pos"}, donepos_q[rd_idx], FRAME - 1);
      rd_idx++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int i;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst tx", 32'(tx), 1);
    check("rst ready", 32'(ready_in), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(word_done), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("req after rst", 32'(ready_in), 1);

    // Single word 0xA5: 0,1,0,1,0,0,1,0,1,1 (LSB first), one word_done
    d0 = done_cnt;
    fifo_q.push_back(8'hA5);
    run_until(1, 200, 1'b1, "a5");
    repeat (4) @(negedge clk);
    check_frame("a5", A5_FRAME);
    check("a5 done count", 32'(done_cnt - d0), 1);

    // Burst of words through the FIFO model, in order, no duplicates
    d0 = done_cnt;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h07);
    run_until(4, 4 * (FRAME + 20), 1'b1, "burst");
    repeat (3 * FRAME) begin
      @(negedge clk);
      fifo_step();
    end
    check("burst fifo empty", 32'(fifo_q.size()), 0);
    check("burst frame count", 32'(frames_q.size() - rd_idx), 4);
    check_frame("w00", exp_frame(8'h00));
    check_frame("wFF", exp_frame(8'hFF));
    check_frame("w3C", exp_frame(8'h3C));
    check_frame("w07", exp_frame(8'h07));
    check("burst done count", 32'(done_cnt - d0), 4);
    check("burst waiting req", 32'(ready_in), 1);

    // Valid drops one cycle after rising with SAMPLE_DELAY=2 -> abort, no frame
    d0 = done_cnt;
    @(negedge clk);
    data_in = 8'h55;
    data_in_valid = 1'b1;
    @(negedge clk);
    check("abort capture ready", 32'(ready_in), 1);
    data_in_valid = 1'b0;
    @(negedge clk);
    check("abort ready low", 32'(ready_in), 0);
    check("abort busy", 32'(busy), 0);
    @(negedge clk);
    check("abort rerequest", 32'(ready_in), 1);
    repeat (FRAME) @(negedge clk);
    check("abort no frame", 32'(frames_q.size() - rd_idx), 0);
    check("abort no done", 32'(done_cnt - d0), 0);
    check("abort tx idle", 32'(tx), 1);

    // Valid held high after ready_in falls -> frame sent, then wait in IDLE
    @(negedge clk);
    data_in = 8'h81;
    data_in_valid = 1'b1;
    i = 0;
    while (ready_in && i < 10) begin
      @(negedge clk);
      i++;
    end
    check("hold ready fell", 32'(ready_in), 0);
    run_until(1, FRAME + 20, 1'b0, "hold");
    repeat (5) @(negedge clk);
    check("hold ready stays low", 32'(ready_in), 0);
    check("hold busy", 32'(busy), 0);
    check_frame("hold", exp_frame(8'h81));
    data_in_valid = 1'b0;
    @(negedge clk);
    check("hold rerequest", 32'(ready_in), 1);

    // Reset pulse in the middle of the data bits
    fifo_q.push_back(8'hC3);
    i = 0;
    while (!busy && i < 40) begin
      @(negedge clk);
      fifo_step();
      i++;
    end
    check("mid busy", 32'(busy), 1);
    repeat (3 * C) begin
      @(negedge clk);
      fifo_step();
    end
    check("mid data bit2", 32'(tx), 0);
    reset_n = 1'b0;
    #1;
    check("mid rst tx", 32'(tx), 1);
    check("mid rst ready", 32'(ready_in), 0);
    check("mid rst busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("mid partial dropped", 32'(frames_q.size() - rd_idx), 0);
    d0 = done_cnt;
    fifo_q.push_back(8'h5A);
    run_until(1, 200, 1'b1, "after rst");
    repeat (4) @(negedge clk);
    check_frame("after rst", exp_frame(8'h5A));
    check("after rst done count", 32'(done_cnt - d0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
